// File: rtl/common_clkgate_ctrl.sv
// Clock-enable sequencer for a shared gated clock subtree: 4-phase req/ack per requester,
// fixed wake-up delay before ack, hysteresis hold before gating the clock off.
module common_clkgate_ctrl #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WAKE_CYC = 4,
  parameter int unsigned IDLE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               force_on_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               clk_en_o,
  output logic [1:0]         state_o,
  output logic [15:0]        wake_cnt_o
);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StWake = 2'd1,
    StOn   = 2'd2,
    StHold = 2'd3
  } state_e;

  localparam logic [7:0] WakeLoad = 8'(WAKE_CYC - 1);
  localparam logic [7:0] IdleLoad = 8'(IDLE_CYC - 1);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [15:0]          wake_cnt_q, wake_cnt_d;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 clk_en_q;
  logic                 any_req;

  assign any_req = (|req_i) | force_on_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      StOff: begin
        if (any_req) begin
          state_d = StWake;
          cnt_d   = WakeLoad;
          if (wake_cnt_q != 16'hFFFF) wake_cnt_d = wake_cnt_q + 16'd1;
        end
      end
      // Wake-up always completes, even if every request has already gone away.
      StWake: begin
        if (cnt_q == 8'd0) state_d = StOn;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StOn: begin
        if (!any_req) begin
          state_d = StHold;
          cnt_d   = IdleLoad;
        end
      end
      // A new request wins over an expiring hold count.
      StHold: begin
        if (any_req)              state_d = StOn;
        else if (cnt_q == 8'd0)   state_d = StOff;
        else                      cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StOff;
      cnt_q      <= 8'd0;
      wake_cnt_q <= 16'd0;
      ack_q      <= '0;
      clk_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ack_q      <= (state_d == StOn) ? req_i : '0;
      clk_en_q   <= (state_d != StOff);
    end
  end

  assign ack_o      = ack_q;
  assign clk_en_o   = clk_en_q;
  assign state_o    = state_q;
  assign wake_cnt_o = wake_cnt_q;

endmodule

// File: tb/tb_common_clkgate_ctrl.sv
// Self-checking bench for common_clkgate_ctrl: directed scenarios with literal expectations
// plus randomized requests compared every cycle against a timing-based reference model.
module tb_common_clkgate_ctrl;

  localparam int unsigned NR   = 4;
  localparam int unsigned WAKE = 4;
  localparam int unsigned IDLE = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_i = '0;
  logic          force_on_i = 1'b0;
  logic [NR-1:0] ack_o;
  logic          clk_en_o;
  logic [1:0]    state_o;
  logic [15:0]   wake_cnt_o;

  int checks = 0;
  int failures = 0;

  common_clkgate_ctrl #(
    .NUM_REQ (NR),
    .WAKE_CYC(WAKE),
    .IDLE_CYC(IDLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .force_on_i(force_on_i),
    .ack_o     (ack_o),
    .clk_en_o  (clk_en_o),
    .state_o   (state_o),
    .wake_cnt_o(wake_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus "cycles left in this phase".
  int          m_phase;  // 0 off, 1 waking, 2 on, 3 holding
  int          m_left;
  int          m_wakes;
  logic [NR-1:0] m_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_wakes = 0;
      m_ack   = '0;
    end else begin
      if (m_phase == 0) begin
        if ((req_i != 0) || force_on_i) begin
          m_phase = 1;
          m_left  = WAKE;
          m_wakes = (m_wakes < 65535) ? m_wakes + 1 : 65535;
        end
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) m_phase = 2;
      end else if (m_phase == 2) begin
        if ((req_i == 0) && !force_on_i) begin
          m_phase = 3;
          m_left  = IDLE;
        end
      end else begin
        if ((req_i != 0) || force_on_i) m_phase = 2;
        else begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 0;
        end
      end
      m_ack = (m_phase == 2) ? req_i : '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_state", 32'(state_o), 32'(m_phase));
      chk("model_clk_en", 32'(clk_en_o), 32'(m_phase != 0));
      chk("model_ack", 32'(ack_o), 32'(m_ack));
      chk("model_wake_cnt", 32'(wake_cnt_o), 32'(m_wakes));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    edges(3);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_clk_en", 32'(clk_en_o), 32'd0);
    chk("reset_ack", 32'(ack_o), 32'd0);
    chk("reset_wake_cnt", 32'(wake_cnt_o), 32'd0);
    rst = 1'b0;
    edges(4);
    chk("idle_after_reset", 32'(clk_en_o), 32'd0);

    // Single wake from OFF
    req_i = 4'b0001;
    edges(1);
    chk("wake_clk_en", 32'(clk_en_o), 32'd1);
    chk("wake_state", 32'(state_o), 32'd1);
    edges(3);
    chk("wake_no_ack_yet", 32'(ack_o), 32'd0);
    edges(1);
    chk("on_state", 32'(state_o), 32'd2);
    chk("on_ack", 32'(ack_o), 32'b0001);
    chk("on_wake_cnt", 32'(wake_cnt_o), 32'd1);
    edges(15);
    req_i = '0;
    edges(1);
    chk("drop_ack", 32'(ack_o), 32'd0);
    chk("drop_hold", 32'(state_o), 32'd3);
    edges(15);
    chk("hold_last_clk_en", 32'(clk_en_o), 32'd1);
    edges(1);
    chk("off_clk_en", 32'(clk_en_o), 32'd0);
    chk("off_state", 32'(state_o), 32'd0);

    // Re-request during HOLD
    req_i = 4'b0100;
    edges(6);
    req_i = '0;
    edges(10);
    req_i = 4'b0100;
    edges(1);
    chk("rereq_ack", 32'(ack_o), 32'b0100);
    chk("rereq_state", 32'(state_o), 32'd2);
    chk("rereq_wake_cnt", 32'(wake_cnt_o), 32'd2);

    // Request arriving on the edge where the hold count expires
    req_i = '0;
    edges(16);
    chk("race_pre_state", 32'(state_o), 32'd3);
    req_i = 4'b0001;
    edges(1);
    chk("race_state", 32'(state_o), 32'd2);
    chk("race_clk_en", 32'(clk_en_o), 32'd1);
    chk("race_ack", 32'(ack_o), 32'b0001);

    // Overlapping requesters
    req_i = 4'b0011;
    edges(1);
    chk("overlap_ack1", 32'(ack_o), 32'b0011);
    req_i = 4'b0010;
    edges(1);
    chk("overlap_ack2", 32'(ack_o), 32'b0010);
    chk("overlap_state", 32'(state_o), 32'd2);
    req_i = '0;
    edges(20);

    // Request dropped during WAKE still passes through ON
    req_i = 4'b1000;
    edges(1);
    req_i = '0;
    edges(4);
    chk("abort_on", 32'(state_o), 32'd2);
    chk("abort_ack", 32'(ack_o), 32'd0);
    edges(20);

    // force_on alone
    force_on_i = 1'b1;
    edges(5);
    chk("force_state", 32'(state_o), 32'd2);
    chk("force_ack", 32'(ack_o), 32'd0);
    edges(5);
    force_on_i = 1'b0;
    edges(16);
    chk("force_hold", 32'(state_o), 32'd3);
    edges(1);
    chk("force_off", 32'(state_o), 32'd0);

    // Asynchronous reset mid-ON
    req_i = 4'b1111;
    edges(8);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_clk_en", 32'(clk_en_o), 32'd0);
    chk("async_rst_ack", 32'(ack_o), 32'd0);
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_wake_cnt", 32'(wake_cnt_o), 32'd0);
    req_i = '0;
    edges(3);
    rst = 1'b0;
    edges(5);
    chk("post_rst_idle", 32'(clk_en_o), 32'd0);

    // Randomized traffic with periodic quiet windows so the block reaches OFF
    for (int i = 0; i < 3000; i++) begin
      if ((i % 400) >= 340) begin
        req_i = '0;
        force_on_i = 1'b0;
      end else begin
        if ($urandom_range(7) == 0) req_i = NR'($urandom);
        if ($urandom_range(31) == 0) force_on_i = ($urandom_range(3) == 0);
      end
      edges(1);
    end
    req_i = '0;
    force_on_i = 1'b0;
    edges(20);

    // Saturation: preload the counter near its ceiling
    force dut.wake_cnt_q = 16'hFFFD;
    m_wakes = 32'hFFFD;
    #1 release dut.wake_cnt_q;
    for (int k = 0; k < 4; k++) begin
      req_i = 4'b0001;
      edges(6);
      req_i = '0;
      edges(18);
    end
    chk("sat_wake_cnt", 32'(wake_cnt_o), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
